// File: rtl/q_8_42_pkg.sv
// ---------------------------------------------------------------------------
// q_8_42_pkg
// Shared types for the q_8_42 count-ones slice.
//   cnt_state_t  : state type of the serial count-ones unit
//   disp_state_t : state type of the dispatcher that feeds that unit
//   fifo_level_w : width of a FIFO occupancy count for a given depth
// ---------------------------------------------------------------------------
package q_8_42_pkg;

  // Count-ones unit states.
  localparam logic [1:0] CNT_IDLE_ENC  = 2'b00;
  localparam logic [1:0] CNT_SHIFT_ENC = 2'b01;
  localparam logic [1:0] CNT_DONE_ENC  = 2'b10;

  typedef enum logic [1:0] {
    CNT_IDLE  = CNT_IDLE_ENC,
    CNT_SHIFT = CNT_SHIFT_ENC,
    CNT_DONE  = CNT_DONE_ENC
  } cnt_state_t;

  // Dispatcher states. Encoding 2'b11 is unused and recovers to S_IDLE.
  localparam logic [1:0] S_IDLE_ENC = 2'b00;
  localparam logic [1:0] S_BUSY_ENC = 2'b01;
  localparam logic [1:0] S_RUN_ENC  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = S_IDLE_ENC,
    S_BUSY = S_BUSY_ENC,
    S_RUN  = S_RUN_ENC
  } disp_state_t;

  // Occupancy needs one bit more than the pointer so "full" is representable.
  function automatic int fifo_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/q_8_42_fifo.sv
// ---------------------------------------------------------------------------
// q_8_42_fifo
// Synchronous single-clock FIFO without bypass. A word written at edge N
// appears on rdata from cycle N+1. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally at their bit width.
// Ports:
//   clk, rst_b      : clock, synchronous active-low reset (control only)
//   push, wdata     : write request and word; ignored while full
//   pop             : read request; ignored while empty
//   rdata           : word at the head of the FIFO
//   full, empty     : occupancy flags
//   level           : number of words held
// ---------------------------------------------------------------------------
module q_8_42_fifo
  import q_8_42_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [fifo_level_w(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = fifo_level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  // A push while full is dropped even if a pop frees a slot at the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/q_8_42_dispatch.sv
// ---------------------------------------------------------------------------
// q_8_42_dispatch
// Buffers upstream words in a FIFO and feeds them one at a time to an
// external count-ones unit, then presents {word, ones-count} downstream.
// Ports:
//   clk, rst_b                  : clock, synchronous active-low reset
//   in_valid/in_ready/in_data   : upstream word push (in_ready = !full)
//   cnt_start/cnt_data          : start pulse and operand to count-ones unit
//   cnt_rdy/cnt_count           : unit ready flag and its result
//   res_valid/res_ready/
//   res_data/res_count          : downstream result handshake
//   fifo_level                  : words currently queued
// Handshake with the unit: after a start pulse the unit drops cnt_rdy for at
// least one cycle; its rise again marks cnt_count as valid.
// ---------------------------------------------------------------------------
module q_8_42_dispatch
  import q_8_42_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           cnt_start,
  output logic [WIDTH-1:0]               cnt_data,
  input  logic                           cnt_rdy,
  input  logic [$clog2(WIDTH+1)-1:0]     cnt_count,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [WIDTH-1:0]               res_data,
  output logic [$clog2(WIDTH+1)-1:0]     res_count,
  output logic [fifo_level_w(DEPTH)-1:0] fifo_level
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_head;

  disp_state_t      state;
  disp_state_t      state_nxt;
  logic             launch;
  logic             capture;
  logic             res_slot_free;

  logic [WIDTH-1:0] inflight_data_p1;
  logic             inflight_vld_p1;

  q_8_42_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (launch),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // in_ready depends only on registered occupancy, never on res_ready.
  assign in_ready = !fifo_full;

  // Operand reads as zero whenever nothing is queued.
  assign cnt_data = fifo_empty ? '0 : fifo_head;

  // The result slot can take a new word if it is empty or is being drained
  // at this same edge; that lets acceptance and a new launch coincide.
  assign res_slot_free = !res_valid || res_ready;

  assign launch    = (state == S_IDLE) && !fifo_empty && cnt_rdy && res_slot_free;
  assign cnt_start = launch;

  assign capture   = (state == S_RUN) && cnt_rdy && inflight_vld_p1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch)   state_nxt = S_BUSY;
      // Wait for the unit to acknowledge the start by dropping cnt_rdy,
      // so a stale high cnt_rdy is never mistaken for completion.
      S_BUSY:  if (!cnt_rdy) state_nxt = S_RUN;
      S_RUN:   if (cnt_rdy)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- stage p1: word handed to the count-ones unit ----
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      inflight_vld_p1 <= 1'b0;
    end else if (launch) begin
      inflight_vld_p1 <= 1'b1;
    end else if (capture) begin
      inflight_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (launch) inflight_data_p1 <= fifo_head;
  end

  // ---- stage p2: result register toward downstream ----
  // A capture can never land on an unaccepted result: launch only happens
  // when the slot is free, and nothing else sets res_valid meanwhile.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_count <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_data  <= inflight_data_p1;
      res_count <= cnt_count[CW-1:0];
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_q_8_42_dispatch.sv
module tb_q_8_42_dispatch;
  import q_8_42_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             cnt_start;
  logic [WIDTH-1:0] cnt_data;
  logic             cnt_rdy;
  logic [CW-1:0]    cnt_count;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [CW-1:0]    res_count;
  logic [LW-1:0]    fifo_level;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    c;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;

  q_8_42_dispatch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .cnt_start  (cnt_start),
    .cnt_data   (cnt_data),
    .cnt_rdy    (cnt_rdy),
    .cnt_count  (cnt_count),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_count  (res_count),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] ref_pop(input logic [WIDTH-1:0] w);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(w[i]);
    return CW'(n);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Count-ones unit model: cnt_rdy drops for max(1, popcount) cycles.
  int            cu_rem;
  logic [CW-1:0] cu_pend;
  always @(posedge clk) begin
    if (!rst_b) begin
      cnt_rdy   <= 1'b1;
      cu_rem    <= 0;
      cnt_count <= '0;
    end else if (cnt_start && cnt_rdy) begin
      cnt_rdy <= 1'b0;
      cu_pend <= ref_pop(cnt_data);
      cu_rem  <= (ref_pop(cnt_data) == '0) ? 1 : int'(ref_pop(cnt_data));
    end else if (!cnt_rdy) begin
      if (cu_rem <= 1) begin
        cnt_rdy   <= 1'b1;
        cnt_count <= cu_pend;
      end else begin
        cu_rem <= cu_rem - 1;
      end
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  logic             hold_v = 1'b0;
  logic [WIDTH-1:0] hold_d;
  logic [CW-1:0]    hold_c;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_b !== 1'b1) begin
        sb.delete();
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("hold_valid", 32'(res_valid), 32'd1);
          chk("hold_data",  32'(res_data),  32'(hold_d));
          chk("hold_count", 32'(res_count), 32'(hold_c));
        end
        hold_v = 1'b0;
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL stale_result: got data %0h count %0d with none expected", res_data, res_count);
          end else begin
            e_pop = sb.pop_front();
            chk("sb_data",  32'(res_data),  32'(e_pop.d));
            chk("sb_count", 32'(res_count), 32'(e_pop.c));
          end
        end else if (res_valid) begin
          hold_v = 1'b1;
          hold_d = res_data;
          hold_c = res_count;
        end
        if (in_valid && in_ready) sb.push_back('{d: in_data, c: ref_pop(in_data)});
        if (cnt_start) chk("start_while_busy", 32'(cnt_rdy), 32'd1);
        chk("in_ready_level", 32'(in_ready), 32'(fifo_level != LW'(DEPTH)));
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic push_word(input logic [WIDTH-1:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && !res_valid && fifo_level == '0 && cnt_rdy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(sb.size() == 0 && !res_valid && fifo_level == '0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (!res_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("res_timeout", 32'(res_valid), 32'd1);
  endtask

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    c;
  } vec_t;

  vec_t vecs[8];
  logic rnd_done;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{d: 8'hB5, c: 4'd5};
    vecs[1] = '{d: 8'h00, c: 4'd0};
    vecs[2] = '{d: 8'hFF, c: 4'd8};
    vecs[3] = '{d: 8'h01, c: 4'd1};
    vecs[4] = '{d: 8'h80, c: 4'd1};
    vecs[5] = '{d: 8'h3C, c: 4'd4};
    vecs[6] = '{d: 8'h5A, c: 4'd4};
    vecs[7] = '{d: 8'h7E, c: 4'd6};

    rst_b     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b1;
    rnd_done  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),   32'd1);
    chk("rst_res_valid", 32'(res_valid),  32'd0);
    chk("rst_level",     32'(fifo_level), 32'd0);
    chk("rst_cnt_start", 32'(cnt_start),  32'd0);
    chk("rst_cnt_data",  32'(cnt_data),   32'd0);
    chk("rst_res_data",  32'(res_data),   32'd0);
    chk("rst_res_count", 32'(res_count),  32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;

    // Table: single words, launch the cycle after the push, result checked.
    for (int i = 0; i < 8; i++) begin
      push_word(vecs[i].d);
      @(negedge clk);
      chk("tbl_start", 32'(cnt_start), 32'd1);
      chk("tbl_cnt_data", 32'(cnt_data), 32'(vecs[i].d));
      wait_res();
      chk("tbl_res_data",  32'(res_data),  32'(vecs[i].d));
      chk("tbl_res_count", 32'(res_count), 32'(vecs[i].c));
      @(posedge clk);
      #1;
    end
    wait_idle();

    // Zero word then all-ones back to back.
    push_word(8'h00);
    push_word(8'hFF);
    wait_idle();

    // Backpressure: six pushes with res_ready low.
    res_ready = 1'b0;
    fork
      begin
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        push_word(8'hA4);
        push_word(8'hA5);
        push_word(8'hA6);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (fifo_level != LW'(DEPTH) && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (10) @(negedge clk);
        chk("bp_level",     32'(fifo_level), 32'(DEPTH));
        chk("bp_in_ready",  32'(in_ready),   32'd0);
        chk("bp_res_valid", 32'(res_valid),  32'd1);
        chk("bp_res_data",  32'(res_data),   32'hA1);
        chk("bp_sb_size",   32'(sb.size()),  32'd5);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
      end
    join
    wait_idle();

    // Acceptance and new launch in the same cycle.
    res_ready = 1'b0;
    push_word(8'h11);
    push_word(8'h22);
    @(negedge clk);
    wait_res();
    chk("acc_level_pre", 32'(fifo_level), 32'd1);
    chk("acc_no_start",  32'(cnt_start),  32'd0);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("acc_start",    32'(cnt_start), 32'd1);
    chk("acc_cnt_data", 32'(cnt_data),  32'h22);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("acc_res_cleared", 32'(res_valid),  32'd0);
    chk("acc_level_post",  32'(fifo_level), 32'd0);
    wait_idle();

    // Reset while in S_RUN with three words queued.
    push_word(8'hFF);
    push_word(8'h01);
    push_word(8'h02);
    push_word(8'h03);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!(dut.state == S_RUN && fifo_level == LW'(3)) && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("rr_reached_run", 32'(dut.state == S_RUN && fifo_level == LW'(3)), 32'd1);
    end
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("rr_level",     32'(fifo_level), 32'd0);
    chk("rr_res_valid", 32'(res_valid),  32'd0);
    chk("rr_state",     32'(dut.state == S_IDLE), 32'd1);
    chk("rr_in_ready",  32'(in_ready),   32'd1);
    repeat (30) @(negedge clk);
    chk("rr_no_stale", 32'(res_valid), 32'd0);
    @(posedge clk);
    #1;

    // Fill and drain DEPTH+3 words across the pointer wrap.
    res_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < DEPTH + 3; i++) push_word(WIDTH'(i * 37 + 5));
      end
      begin
        repeat (25) @(posedge clk);
        #1;
        res_ready = 1'b1;
      end
    join
    wait_idle();

    // Random data with random downstream backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) push_word(WIDTH'($urandom_range(0, 255)));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          res_ready = 1'($urandom_range(0, 1));
        end
        res_ready = 1'b1;
      end
    join
    wait_idle();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/q_8_42_dispatch.md
Q_8_42_DISPATCH -- requirements
Module: q_8_42_dispatch

Interface
REQ-001 Parameter WIDTH, 8, bit width of each data word sent to the count-ones unit.
REQ-002 Parameter DEPTH, 4, input FIFO depth in words; SHALL be a power of 2 and at least 2.
REQ-003 Local CW = $clog2(WIDTH+1), the width of a ones-count.
REQ-004 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_b, input, 1, reset; synchronous and active-low.
REQ-006 Ports in_valid (input, 1), in_ready (output, 1) and in_data (input, WIDTH) form the upstream word-push handshake.
REQ-007 Ports cnt_start (output, 1) and cnt_data (output, WIDTH) drive the count-ones unit's start and operand.
REQ-008 Ports cnt_rdy (input, 1) and cnt_count (input, CW) carry the count-ones unit's ready flag and result.
REQ-009 Ports res_valid (output, 1), res_ready (input, 1), res_data (output, WIDTH) and res_count (output, CW) form the downstream result handshake.
REQ-010 Port fifo_level, output, $clog2(DEPTH)+1, the number of words currently held in the FIFO.

Function
REQ-011 A push SHALL occur on a rising edge where in_valid and in_ready are both 1; in_ready SHALL equal !full, with no write-through when full, even if a pop happens in the same cycle.
REQ-012 The FIFO SHALL have no bypass: a word pushed at edge N is first visible on cnt_data in cycle N+1.
REQ-013 Read and write pointers SHALL wrap modulo DEPTH; a simultaneous push and pop when not full SHALL leave fifo_level unchanged.
REQ-014 The FSM SHALL have three states, S_IDLE, S_BUSY and S_RUN, held in disp_state_t.
REQ-015 The launch condition is: state is S_IDLE, the FIFO is not empty, cnt_rdy is 1, and (res_valid is 0 or res_ready is 1).
REQ-016 On launch, cnt_start SHALL be 1 for exactly one cycle with cnt_data = FIFO head; at that edge the FIFO SHALL pop, the head SHALL be latched into the in-flight register, and the FSM SHALL move to S_BUSY.
REQ-017 cnt_start SHALL be 0 in every cycle other than a launch cycle.
REQ-018 In S_BUSY, the FSM SHALL move to S_RUN once cnt_rdy is 0, and otherwise stay in S_BUSY.
REQ-019 In S_RUN, when cnt_rdy is 1 the block SHALL, at that edge, load res_count with cnt_count and res_data with the in-flight word, set res_valid to 1 and return to S_IDLE.
REQ-020 This SHALL work correctly for a zero word, where cnt_rdy is low for only one cycle.
REQ-021 res_valid, res_data and res_count SHALL remain stable until an edge with res_ready = 1, which clears res_valid unless a new result is captured at that same edge.
REQ-022 When a result is accepted and a new launch occur in the same cycle, both SHALL take effect.
REQ-023 At most one word SHALL be in flight in the count-ones unit at a time.
REQ-024 No combinational path SHALL exist from res_ready to in_ready.
REQ-025 Illegal state encodings SHALL force the FSM to S_IDLE.

Reset
REQ-026 When rst_b is 0 at a rising edge, the block SHALL reset: state is S_IDLE, both pointers are 0, fifo_level is 0, in_ready is 1 and res_valid is 0.
REQ-027 Also on reset, res_data and res_count SHALL be 0, cnt_start SHALL be 0 and cnt_data SHALL be 0.
REQ-028 A reset in S_BUSY or S_RUN SHALL discard the in-flight word and all FIFO contents, with no result produced.
REQ-029 rst_b SHALL also reset the count-ones unit, so cnt_rdy is 1 after reset.

Structure
REQ-030 disp_state_t SHALL be added to the shared package q_8_42_pkg, alongside the existing counter state type.
REQ-031 The FIFO SHALL be a sub-module q_8_42_fifo with parameters WIDTH and DEPTH, carrying push/pop/full/empty/level.
REQ-032 The FSM, in-flight register and result register SHALL reside in q_8_42_dispatch.

Verification
REQ-033 Directed scenario: push 8'hB5 at edge 0 -> cnt_start=1 in cycle 1 with cnt_data=8'hB5; result is res_count=5, res_data=8'hB5.
REQ-034 Directed scenario: push 8'h00 then 8'hFF back-to-back -> results in order, res_count=0 then res_count=8; cnt_start never high while cnt_rdy=0.
REQ-035 Directed scenario: hold res_ready=0 and push 6 words -> first result is held stable; in_ready=0 once fifo_level=4; the sixth push stalls until res_ready=1.
REQ-036 Directed scenario: with res_valid=1, raise res_ready=1 while the FIFO is non-empty and cnt_rdy=1 -> acceptance and new launch occur in the same cycle.
REQ-037 Directed scenario: assert rst_b=0 for 1 cycle while in S_RUN with 3 words queued -> fifo_level=0, res_valid=0 and state S_IDLE next cycle; no stale result afterwards.
REQ-038 Directed scenario: fill and drain DEPTH+3 words -> pointer wrap causes no loss or duplication; all counts match a reference popcount.
